// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module  : seg7_scan_ctrl
// | Brief   : Time-multiplexed seven-segment scan controller with LT/BI/RBI
// |           style lamp test, blanking and leading-zero suppression.
// | Revision: 1.0 - initial release
// +----------------------------------------------------------------------------
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000,
  parameter int GUARD      = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  output logic                    ready,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    lt_n,
  input  logic                    bi_n,
  input  logic                    lzs_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         disp_q, disp_d;
  logic [DW-1:0]         pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  logic                  w_wrap;
  logic                  w_boundary;
  logic [3:0]            w_sel_digit;
  logic                  w_sel_blank;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = 7'h7E;
      4'd1:    bcd_to_seg = 7'h30;
      4'd2:    bcd_to_seg = 7'h6D;
      4'd3:    bcd_to_seg = 7'h79;
      4'd4:    bcd_to_seg = 7'h33;
      4'd5:    bcd_to_seg = 7'h5B;
      4'd6:    bcd_to_seg = 7'h5F;
      4'd7:    bcd_to_seg = 7'h70;
      4'd8:    bcd_to_seg = 7'h7F;
      4'd9:    bcd_to_seg = 7'h7B;
      default: bcd_to_seg = 7'h01;
    endcase
  endfunction

  assign ready      = !pend_valid_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

  assign w_wrap     = (cnt_q == CNT_LAST);
  assign w_boundary = w_wrap && (idx_q == IDX_LAST);

  // Walk from the most significant digit down; a digit is a leading zero
  // while every digit above it (and itself) is zero. Digit 0 always shows.
  always_comb begin : p_digit_sel
    logic zero_run;
    zero_run    = 1'b1;
    w_sel_digit = 4'd0;
    w_sel_blank = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (disp_q[4*i +: 4] == 4'd0);
      if (idx_q == IW'(i)) begin
        w_sel_digit = disp_q[4*i +: 4];
        w_sel_blank = zero_run && (i != 0);
      end
    end
  end

  always_comb begin
    cnt_d        = w_wrap ? '0 : cnt_q + CW'(1);
    idx_d        = idx_q;
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    frame_done_d = w_boundary;

    if (w_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    // A load only lands when nothing is pending, so a boundary commit and a
    // fresh capture can never collide on the same edge.
    if (w_boundary && pend_valid_q) begin
      disp_d       = pend_q;
      pend_valid_d = 1'b0;
    end else if (load && !pend_valid_q) begin
      pend_d       = bcd_in;
      pend_valid_d = 1'b1;
    end

    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = (cnt_q >= GUARD_C) && (idx_q == IW'(i));
    end

    if (!bi_n) begin
      seg_d = 7'h00;
    end else if (!lt_n) begin
      seg_d = 7'h7F;
    end else if (lzs_en && w_sel_blank) begin
      seg_d = 7'h00;
    end else begin
      seg_d = bcd_to_seg(w_sel_digit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      seg_q        <= 7'h00;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module  : tb_seg7_scan_ctrl
// | Brief   : Self-checking bench for seg7_scan_ctrl (N=4, PRESCALE=4, GUARD=1).
// | Revision: 1.0 - initial release
// +----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int N = 4;
  localparam int P = 4;
  localparam int G = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic [15:0]  bcd_in = 16'h0;
  logic         lt_n = 1'b1;
  logic         bi_n = 1'b1;
  logic         lzs_en = 1'b0;
  logic         ready;
  logic [6:0]   seg;
  logic [N-1:0] an;
  logic         frame_done;

  int passed = 0;
  int total  = 0;
  logic [6:0] exp_q[$];

  seg7_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .GUARD(G)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .ready(ready), .bcd_in(bcd_in),
    .lt_n(lt_n), .bi_n(bi_n), .lzs_en(lzs_en), .seg(seg), .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 7'h7E; 4'd1: enc = 7'h30; 4'd2: enc = 7'h6D; 4'd3: enc = 7'h79;
      4'd4: enc = 7'h33; 4'd5: enc = 7'h5B; 4'd6: enc = 7'h5F; 4'd7: enc = 7'h70;
      4'd8: enc = 7'h7F; 4'd9: enc = 7'h7B; default: enc = 7'h01;
    endcase
  endfunction

  // Queue the four slot codes expected for a frame showing value v.
  task automatic push_frame(input logic [15:0] v, input logic lz, input logic lt, input logic bi);
    logic [6:0] codes [4];
    logic [3:0] d;
    bit run;
    run = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      d   = v[4*i +: 4];
      run = run && (d == 4'd0);
      if (!bi)                      codes[i] = 7'h00;
      else if (!lt)                 codes[i] = 7'h7F;
      else if (lz && i != 0 && run) codes[i] = 7'h00;
      else                          codes[i] = enc(d);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(codes[i]);
  endtask

  task automatic sync_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 40);
    chk("frame_sync", {15'd0, frame_done}, 16'd1);
  endtask

  // Starts on a negedge where frame_done is high; ends on the next such negedge.
  task automatic run_frame(input string tag, input logic exp_ready_mid,
                           input logic mid_load, input logic [15:0] mid_val);
    logic [6:0] codes [4];
    logic [3:0] ea;
    bit last;
    for (int s = 0; s < 4; s++) begin
      if (exp_q.size() == 0) begin
        total++;
        $error("FAIL %s_scoreboard: observed empty expected entry", tag);
        codes[s] = 7'h00;
      end else begin
        codes[s] = exp_q.pop_front();
      end
    end
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < P; c++) begin
        @(negedge clk);
        load = 1'b0;
        if (mid_load && s == 1 && c == 2) begin
          load   = 1'b1;
          bcd_in = mid_val;
        end
        last = (s == 3) && (c == P - 1);
        ea   = (c >= G) ? 4'(1 << s) : 4'b0000;
        chk({tag, "_an"},  {12'd0, an},  {12'd0, ea});
        chk({tag, "_seg"}, {9'd0, seg},  {9'd0, codes[s]});
        chk({tag, "_fd"},  {15'd0, frame_done}, {15'd0, last});
        chk({tag, "_rdy"}, {15'd0, ready}, {15'd0, (last ? 1'b1 : exp_ready_mid)});
      end
    end
  endtask

  initial begin
    #2;
    chk("rst_seg", {9'd0, seg}, 16'h0000);
    chk("rst_an", {12'd0, an}, 16'h0000);
    chk("rst_ready", {15'd0, ready}, 16'd1);
    chk("rst_fd", {15'd0, frame_done}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sync_frame();

    push_frame(16'h0000, 0, 1, 1);
    run_frame("idle", 1'b1, 1'b0, 16'h0);

    load = 1'b1; bcd_in = 16'h1234;
    push_frame(16'h0000, 0, 1, 1);
    push_frame(16'h1234, 0, 1, 1);
    run_frame("l1234_pre", 1'b0, 1'b0, 16'h0);
    run_frame("l1234", 1'b1, 1'b0, 16'h0);

    lzs_en = 1'b1; load = 1'b1; bcd_in = 16'h0005;
    push_frame(16'h1234, 1, 1, 1);
    push_frame(16'h0005, 1, 1, 1);
    run_frame("l0005_pre", 1'b0, 1'b0, 16'h0);
    run_frame("l0005", 1'b1, 1'b0, 16'h0);

    load = 1'b1; bcd_in = 16'h0000;
    push_frame(16'h0005, 1, 1, 1);
    push_frame(16'h0000, 1, 1, 1);
    run_frame("l0000_pre", 1'b0, 1'b0, 16'h0);
    run_frame("l0000_lzs", 1'b1, 1'b0, 16'h0);

    lzs_en = 1'b0;
    push_frame(16'h0000, 0, 1, 1);
    run_frame("l0000_nolzs", 1'b1, 1'b0, 16'h0);

    lt_n = 1'b0;
    push_frame(16'h0000, 0, 0, 1);
    run_frame("lamp", 1'b1, 1'b0, 16'h0);
    bi_n = 1'b0;
    push_frame(16'h0000, 0, 0, 0);
    run_frame("blank", 1'b1, 1'b0, 16'h0);
    lt_n = 1'b1; bi_n = 1'b1;
    push_frame(16'h0000, 0, 1, 1);
    run_frame("unblank", 1'b1, 1'b0, 16'h0);

    lzs_en = 1'b1; load = 1'b1; bcd_in = 16'h00A9;
    push_frame(16'h0000, 1, 1, 1);
    push_frame(16'h00A9, 1, 1, 1);
    push_frame(16'h00A9, 1, 1, 1);
    run_frame("lA9_pre", 1'b0, 1'b1, 16'h1111);
    run_frame("lA9", 1'b1, 1'b0, 16'h0);
    run_frame("lA9_hold", 1'b1, 1'b0, 16'h0);

    load = 1'b1; bcd_in = 16'h8888;
    @(negedge clk);
    load = 1'b0;
    repeat (8) @(negedge clk);
    chk("pend_before_rst", {15'd0, ready}, 16'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_seg", {9'd0, seg}, 16'h0000);
    chk("midrst_an", {12'd0, an}, 16'h0000);
    chk("midrst_ready", {15'd0, ready}, 16'd1);
    chk("midrst_fd", {15'd0, frame_done}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    lzs_en = 1'b0;
    sync_frame();
    push_frame(16'h0000, 0, 1, 1);
    run_frame("post_rst", 1'b1, 1'b0, 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
